reorder_buffer: RTL and testbench

- Circular reorder buffer between the Dispatcher and the register file (RF) of the out-of-order RISC-V core.
- Allocates one entry per dispatched instruction and collects results from the common data bus (CDB).
- Retires entries strictly in program order: register writes go to the RF and stores are released to the load/store buffer.
- Detects branch mispredictions at retirement and broadcasts the flush and the redirect PC.

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at dispatch, collects CDB results,
// and retires in program order with registered commit/store/flush pulses.
module reorder_buffer #(
  parameter int RoB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_en,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic [31:0]          issue_pc,
  input  logic                 issue_pred_taken,
  output logic                 rob_full,
  output logic [RoB_WIDTH-1:0] rob_tail,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_idx,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  input  logic [31:0]          cdb_target,
  input  logic [RoB_WIDTH-1:0] query1_idx,
  input  logic [RoB_WIDTH-1:0] query2_idx,
  output logic                 query1_ready,
  output logic                 query2_ready,
  output logic [31:0]          query1_value,
  output logic [31:0]          query2_value,
  output logic                 commit_en,
  output logic [RoB_WIDTH-1:0] commit_idx,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 store_commit_en,
  output logic                 flush_out,
  output logic [31:0]          flush_pc
);

  localparam int Depth = 1 << RoB_WIDTH;
  localparam int CntW  = RoB_WIDTH + 1;

  typedef enum logic [1:0] {TypeReg, TypeStore, TypeBranch, TypeRsvd} entry_type_e;

  logic [Depth-1:0]     busy_q, ready_q, pred_q, taken_q;
  entry_type_e          type_q   [Depth];
  logic [4:0]           rd_q     [Depth];
  logic [31:0]          pc_q     [Depth];
  logic [31:0]          value_q  [Depth];
  logic [31:0]          target_q [Depth];

  logic [RoB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  logic                 commit_en_q, store_commit_en_q, flush_q;
  logic [RoB_WIDTH-1:0] commit_idx_q;
  logic [4:0]           commit_rd_q;
  logic [31:0]          commit_value_q, flush_pc_q;

  logic                 do_commit, do_issue, do_cdb, mispredict;
  entry_type_e          head_type;

  assign rob_full        = (count_q == CntW'(Depth));
  assign rob_tail        = tail_q;
  assign commit_en       = commit_en_q;
  assign commit_idx      = commit_idx_q;
  assign commit_rd       = commit_rd_q;
  assign commit_value    = commit_value_q;
  assign store_commit_en = store_commit_en_q;
  assign flush_out       = flush_q;
  assign flush_pc        = flush_pc_q;

  // Operand lookups forward a same-cycle CDB broadcast ahead of the stored result
  always_comb begin
    query1_ready = ready_q[query1_idx] || (cdb_en && (cdb_idx == query1_idx));
    query2_ready = ready_q[query2_idx] || (cdb_en && (cdb_idx == query2_idx));
    query1_value = (cdb_en && (cdb_idx == query1_idx)) ? cdb_value : value_q[query1_idx];
    query2_value = (cdb_en && (cdb_idx == query2_idx)) ? cdb_value : value_q[query2_idx];
  end

  // A full buffer may still accept an issue when the head retires in the same cycle
  always_comb begin
    head_type  = type_q[head_q];
    do_commit  = rdy_in && busy_q[head_q] && ready_q[head_q];
    mispredict = do_commit && (head_type == TypeBranch) &&
                 (taken_q[head_q] != pred_q[head_q]);
    do_issue   = rdy_in && issue_en && (!rob_full || do_commit) && !mispredict;
    do_cdb     = rdy_in && cdb_en && busy_q[cdb_idx] && !mispredict;
    head_d     = do_commit ? head_q + RoB_WIDTH'(1) : head_q;
    tail_d     = do_issue ? tail_q + RoB_WIDTH'(1) : tail_q;
    count_d    = count_q + CntW'(do_issue) - CntW'(do_commit);
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Later writes win: commit clears the head, a wrapping issue may reclaim it, flush clears all
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      busy_q            <= '0;
      ready_q           <= '0;
      pred_q            <= '0;
      taken_q           <= '0;
      commit_en_q       <= 1'b0;
      store_commit_en_q <= 1'b0;
      flush_q           <= 1'b0;
      commit_idx_q      <= '0;
      commit_rd_q       <= '0;
      commit_value_q    <= '0;
      flush_pc_q        <= '0;
      for (int i = 0; i < Depth; i++) begin
        type_q[i]   <= TypeReg;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      commit_en_q       <= 1'b0;
      store_commit_en_q <= 1'b0;
      flush_q           <= 1'b0;
      if (do_cdb) begin
        ready_q[cdb_idx]  <= 1'b1;
        value_q[cdb_idx]  <= cdb_value;
        taken_q[cdb_idx]  <= cdb_taken;
        target_q[cdb_idx] <= cdb_target;
      end
      if (do_commit) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        commit_idx_q    <= head_q;
        commit_rd_q     <= rd_q[head_q];
        commit_value_q  <= value_q[head_q];
        case (head_type)
          TypeStore:  store_commit_en_q <= 1'b1;
          TypeBranch: begin
            if (mispredict) begin
              flush_q    <= 1'b1;
              flush_pc_q <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
            end
          end
          default:    commit_en_q <= (rd_q[head_q] != 5'd0);
        endcase
      end
      if (do_issue) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        type_q[tail_q]  <= entry_type_e'(issue_type);
        rd_q[tail_q]    <= issue_rd;
        pc_q[tail_q]    <= issue_pc;
        pred_q[tail_q]  <= issue_pred_taken;
      end
      if (mispredict) begin
        busy_q  <= '0;
        ready_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: an in-order queue model predicts retire
// events; a negedge monitor compares every pulse, plus rob_full/rob_tail each cycle.
module tb_reorder_buffer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  idx;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] fpc;
  } ev_t;

  localparam logic [1:0] KReg = 2'd0, KSt = 2'd1, KFl = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_en, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        rob_full;
  logic [2:0]  rob_tail;
  logic        cdb_en, cdb_taken;
  logic [2:0]  cdb_idx;
  logic [31:0] cdb_value, cdb_target;
  logic [2:0]  query1_idx, query2_idx;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_value, query2_value;
  logic        commit_en, store_commit_en, flush_out;
  logic [2:0]  commit_idx;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;

  int   errors = 0;
  int   checks = 0;
  bit   monOn = 0;
  ent_t mq[$];
  ev_t  expq[$];
  logic [2:0] mtail;
  ent_t mh;
  ev_t  mev;
  bit   mfl;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.RoB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .query1_idx(query1_idx), .query2_idx(query2_idx),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .commit_en(commit_en), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_value(commit_value), .store_commit_en(store_commit_en),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: program-order queue; oldest finished entry retires, one per edge
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mq.delete();
      expq.delete();
      mtail = 3'd0;
    end else if (rdy_in) begin
      mfl = 0;
      if (mq.size() > 0 && mq[0].done) begin
        mh  = mq.pop_front();
        mev = '0;
        mev.idx = mh.idx;
        mev.rd  = mh.rd;
        mev.val = mh.val;
        if (mh.ty == 2'd2) begin
          if (mh.taken != mh.pred) begin
            mfl      = 1;
            mev.kind = KFl;
            mev.fpc  = mh.taken ? mh.tgt : mh.pc + 32'd4;
            expq.push_back(mev);
          end
        end else if (mh.ty == 2'd1) begin
          mev.kind = KSt;
          expq.push_back(mev);
        end else if (mh.rd != 5'd0) begin
          mev.kind = KReg;
          expq.push_back(mev);
        end
      end
      if (mfl) begin
        mq.delete();
        mtail = 3'd0;
      end else begin
        if (cdb_en)
          for (int i = 0; i < mq.size(); i++)
            if (mq[i].idx == cdb_idx) begin
              mq[i].done  = 1'b1;
              mq[i].val   = cdb_value;
              mq[i].taken = cdb_taken;
              mq[i].tgt   = cdb_target;
            end
        if (issue_en && mq.size() < 8) begin
          mh = '0;
          mh.idx = mtail; mh.ty = issue_type; mh.rd = issue_rd;
          mh.pc = issue_pc; mh.pred = issue_pred_taken;
          mq.push_back(mh);
          mtail = mtail + 3'd1;
        end
      end
    end
  end

  // Monitor: every pulse must match the next expected retire event, in order
  always @(negedge clk_in) begin
    ev_t ev;
    if (monOn) begin
      if (!rst_in) begin
        checkOutput("rst_pulses", {commit_en, store_commit_en, flush_out}, 64'd0);
        checkOutput("rst_tail_full", {rob_full, rob_tail}, 64'd0);
      end else begin
        checkOutput("rob_full", rob_full, (mq.size() == 8));
        checkOutput("rob_tail", rob_tail, mtail);
        if (expq.size() > 0) begin
          ev = expq.pop_front();
          checkOutput("commit_en", commit_en, ev.kind == KReg);
          checkOutput("store_commit_en", store_commit_en, ev.kind == KSt);
          checkOutput("flush_out", flush_out, ev.kind == KFl);
          if (ev.kind == KReg) begin
            checkOutput("commit_idx", commit_idx, ev.idx);
            checkOutput("commit_rd", commit_rd, ev.rd);
            checkOutput("commit_value", commit_value, ev.val);
          end else if (ev.kind == KSt) begin
            checkOutput("store_idx", commit_idx, ev.idx);
          end else begin
            checkOutput("flush_pc", flush_pc, ev.fpc);
          end
        end else begin
          checkOutput("no_pulse", {commit_en, store_commit_en, flush_out}, 64'd0);
        end
      end
    end
  end

  function automatic void expQuery(input logic [2:0] idx, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[i]) if (mq[i].idx == idx && mq[i].done) begin r = 1'b1; v = mq[i].val; end
    if (cdb_en && cdb_idx == idx) begin r = 1'b1; v = cdb_value; end
  endfunction

  task automatic applyStimulus(input logic iss, input logic [1:0] ty, input logic [4:0] rd,
                               input logic [31:0] pc, input logic pred, input logic cdb,
                               input logic [2:0] cidx, input logic [31:0] cval, input logic ctk,
                               input logic [31:0] ctgt, input logic rdy);
    logic        r;
    logic [31:0] v;
    @(posedge clk_in);
    #2;
    issue_en = iss; issue_type = ty; issue_rd = rd; issue_pc = pc; issue_pred_taken = pred;
    cdb_en = cdb; cdb_idx = cidx; cdb_value = cval; cdb_taken = ctk; cdb_target = ctgt;
    rdy_in = rdy;
    query1_idx = cdb ? cidx : 3'($urandom_range(7));
    query2_idx = 3'($urandom_range(7));
    #1;
    expQuery(query1_idx, r, v);
    checkOutput("q1_ready", query1_ready, r);
    if (r) checkOutput("q1_value", query1_value, v);
    expQuery(query2_idx, r, v);
    checkOutput("q2_ready", query2_ready, r);
    if (r) checkOutput("q2_value", query2_value, v);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 2'd0, 5'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0, 32'd0, 1);
  endtask

  task automatic issueOp(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
    applyStimulus(1, ty, rd, pc, pred, 0, 3'd0, 32'd0, 0, 32'd0, 1);
  endtask

  task automatic completeOp(input logic [2:0] idx, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
    applyStimulus(0, 2'd0, 5'd0, 32'd0, 0, 1, idx, val, tk, tgt, 1);
  endtask

  task automatic randomCycle(input int ip, input int cp, input int rp);
    int   cand[$];
    ent_t e;
    logic cdb, tk;
    e  = '0;
    tk = 1'b0;
    foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
    cdb = (cand.size() > 0) && ($urandom_range(99) < cp);
    if (cdb) begin
      e  = mq[cand[$urandom_range(cand.size() - 1)]];
      tk = (e.ty == 2'd2) ? (($urandom_range(3) == 0) ? ~e.pred : e.pred) : 1'($urandom_range(1));
    end
    applyStimulus($urandom_range(99) < ip, 2'($urandom_range(3)),
                  ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31)),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)),
                  cdb, e.idx, $urandom, tk, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(99) < rp);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_en = 0; issue_type = 0; issue_rd = 0; issue_pc = 0; issue_pred_taken = 0;
    cdb_en = 0; cdb_idx = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
    query1_idx = 0; query2_idx = 0;
    #1 rst_in = 1'b0;
    monOn = 1;
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b1;

    $display("[TB] basic retire");
    issueOp(2'd0, 5'd5, 32'h0, 0);
    completeOp(3'd0, 32'h1234, 0, 32'h0);
    idle(4);

    $display("[TB] full and wrap-around");
    for (int i = 0; i < 8; i++) issueOp(2'd0, 5'(i + 1), 32'(i * 4), 0);
    issueOp(2'd0, 5'd30, 32'h40, 0);
    for (int i = 7; i >= 0; i--) completeOp(mq[i].idx, 32'(32'hA000 + i), 0, 32'h0);
    idle(10);
    for (int i = 0; i < 12; i++) randomCycle(100, 100, 100);
    idle(12);

    $display("[TB] misprediction flush");
    issueOp(2'd2, 5'd0, 32'h100, 0);
    for (int i = 0; i < 3; i++) issueOp(2'd0, 5'(i + 10), 32'(32'h104 + i * 4), 0);
    for (int i = 1; i < 4; i++) completeOp(mq[i].idx, 32'(i), 0, 32'h0);
    completeOp(mq[0].idx, 32'h0, 1, 32'h200);
    idle(4);
    issueOp(2'd2, 5'd0, 32'h100, 1);
    for (int i = 0; i < 3; i++) issueOp(2'd0, 5'(i + 10), 32'(32'h104 + i * 4), 0);
    for (int i = 1; i < 4; i++) completeOp(mq[i].idx, 32'(i), 0, 32'h0);
    completeOp(mq[0].idx, 32'h0, 0, 32'h300);
    idle(4);

    $display("[TB] same-cycle forwarding");
    for (int i = 0; i < 3; i++) issueOp(2'd0, 5'(i + 3), 32'(i * 4), 0);
    completeOp(3'd2, 32'hDEAD, 0, 32'h0);
    checkOutput("fwd_ready", query1_ready, 1);
    checkOutput("fwd_value", query1_value, 32'hDEAD);
    completeOp(3'd0, 32'h11, 0, 32'h0);
    completeOp(3'd1, 32'h22, 0, 32'h0);
    idle(5);

    $display("[TB] store and x0");
    issueOp(2'd1, 5'd4, 32'h500, 0);
    issueOp(2'd0, 5'd0, 32'h504, 0);
    issueOp(2'd0, 5'd7, 32'h508, 0);
    for (int i = 0; i < 3; i++) completeOp(mq[i].idx, 32'(32'h70 + i), 0, 32'h0);
    idle(5);

    $display("[TB] pause");
    issueOp(2'd0, 5'd9, 32'h600, 0);
    completeOp(mq[0].idx, 32'h55AA, 0, 32'h0);
    repeat (3) applyStimulus(0, 2'd0, 5'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0, 32'd0, 0);
    idle(3);

    $display("[TB] async reset mid-stream");
    issueOp(2'd0, 5'd12, 32'h700, 0);
    issueOp(2'd0, 5'd13, 32'h704, 0);
    completeOp(mq[0].idx, 32'hBEEF, 0, 32'h0);
    completeOp(mq[1].idx, 32'hCAFE, 0, 32'h0);
    @(posedge clk_in);
    #3;
    issue_en = 0; cdb_en = 0;
    rst_in = 1'b0;
    #1;
    checkOutput("arst_commit_en", commit_en, 0);
    checkOutput("arst_store", store_commit_en, 0);
    checkOutput("arst_flush", flush_out, 0);
    checkOutput("arst_flush_pc", flush_pc, 0);
    checkOutput("arst_commit_idx", commit_idx, 0);
    checkOutput("arst_commit_rd", commit_rd, 0);
    checkOutput("arst_commit_value", commit_value, 0);
    checkOutput("arst_full", rob_full, 0);
    checkOutput("arst_tail", rob_tail, 0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;

    $display("[TB] random traffic");
    repeat (800) randomCycle(60, 60, 90);
    repeat (80) randomCycle(0, 100, 100);
    idle(4);
    checkOutput("final_full", rob_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
